// File: rtl/sram_1rw_req_ctrl.sv
// Single-port SRAM requester: zero-fills the array after reset, then merges write/read channels onto RW0.
// Latency: write lands at the accept edge; read response is visible two cycles after the read is accepted.
// Backpressure: reads are credit-limited by in-flight responses (pending + buffered); resp_ready never reaches r_ready.
// Build option: define SRAM_CTRL_RR_ARB_EN for round-robin arbitration on contention (default: fixed write priority).
module sram_1rw_req_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int AW         = 10,
    parameter int DW         = 7,
    parameter int RESP_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          r_valid,
    output logic          r_ready,
    input  logic [AW-1:0] r_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          init_done,
    output logic [AW-1:0] sram_addr,
    output logic          sram_en,
    output logic          sram_wmode,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(RESP_DEPTH - 1);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(RESP_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] init_ptr_q, init_ptr_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] fifo_mem_q [RESP_DEPTH];
    logic [DW-1:0] fifo_mem_d [RESP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          run;
    logic [CW:0]   inflight;
    logic          rd_credit;
    logic          w_gnt;
    logic          r_gnt;
    logic          push;
    logic          pop;

    assign run       = (state_q == ST_RUN);
    assign init_done = run;
    // Credit counts the pending read plus everything buffered, ignoring a same-cycle pop,
    // so with RESP_DEPTH=2 streaming reads settle at two grants every three cycles.
    assign inflight  = {1'b0, count_q} + {{CW{1'b0}}, rd_pend_q};
    assign rd_credit = (inflight < CREDIT_MAX);

`ifdef SRAM_CTRL_RR_ARB_EN
    // rr_last_q=1 means the read channel won the last contended cycle.
    logic rr_last_q, rr_last_d;
    logic contend;
    logic pick_read;

    // Round-robin grant: alternate channels only on cycles where both could be served.
    always_comb begin
        contend   = run & w_valid & r_valid & rd_credit;
        pick_read = contend & ~rr_last_q;
        w_gnt     = run & w_valid & ~pick_read;
        r_gnt     = run & r_valid & rd_credit & (~w_valid | pick_read);
        rr_last_d = contend ? pick_read : rr_last_q;
    end

    // Arbitration history register; starts as "read" so the first contention goes to the write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rr_last_q <= 1'b1;
        else          rr_last_q <= rr_last_d;
    end
`else
    // Fixed priority: a valid write always wins; reads wait while w_valid stays high.
    always_comb begin
        w_gnt = run & w_valid;
        r_gnt = run & r_valid & rd_credit & ~w_valid;
    end
`endif

    assign w_ready = run & ~r_gnt;
    assign r_ready = run & rd_credit & ~w_gnt;

    // SRAM port drive: zero-fill sweep in INIT (suppressed while reset is held), else the granted op.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (state_q == ST_INIT) begin
            sram_en    = reset_n;
            sram_wmode = reset_n;
            sram_addr  = init_ptr_q;
        end else if (w_gnt) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wdata = w_data;
        end else if (r_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = r_addr;
        end
    end

    // Sweep pointer and INIT->RUN transition; RUN is only left through reset.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + AW'(1);
            if (init_ptr_q == LAST_ADDR) state_d = ST_RUN;
        end
    end

    assign push       = rd_pend_q;
    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid & resp_ready;
    assign resp_data  = resp_valid ? fifo_mem_q[rd_ptr_q] : '0;

    // Response FIFO: capture sram_rdata the cycle after a read issue; push and pop may coincide.
    always_comb begin
        rd_pend_d  = r_gnt;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = sram_rdata;
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any pending read and buffered responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            rd_pend_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rd_pend_q  <= rd_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

endmodule
